// File: rtl/fft_iter_addr_gen.sv
// Address generator / write sequencer for the iterative radix-2 DIT FFT core.
// Turns controller strobes into butterfly read/write/twiddle addresses and write enables.
module fft_iter_addr_gen #(
    parameter int LAYERS      = 5,
    parameter int BUTTERFLYES = 16,
    parameter int LayWL       = 3,
    parameter int ButtWL      = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              EN,
    input  logic              START,
    input  logic              ADDR_EN,
    input  logic              LAY_EN,
    input  logic              BUT_STROB,
    input  logic              Wr,
    input  logic              FIRST,
    output logic [LAYERS-1:0] RD_ADDR_A,
    output logic [LAYERS-1:0] RD_ADDR_B,
    output logic [LAYERS-1:0] WR_ADDR_A,
    output logic [LAYERS-1:0] WR_ADDR_B,
    output logic [ButtWL-1:0] TW_ADDR,
    output logic              WE,
    output logic              BUSY,
    output logic              DONE,
    output logic              SYNC_ERR
);
    localparam int WCW = LayWL + ButtWL;

    logic [ButtWL-1:0] b, nb;
    logic [LayWL-1:0]  l, nl;
    logic [WCW-1:0]    wcnt;
    logic              iss_done;
    logic              last_wrap;

    logic              adv, wrap, fin, lay_ok;
    logic [LAYERS-1:0] span, grp, a_n, b_n;
    logic [ButtWL-1:0] pos, tw_n;

    always_comb begin
        adv    = BUSY && ADDR_EN && !iss_done;
        wrap   = adv && (b == ButtWL'(BUTTERFLYES-1)) && (l != LayWL'(LAYERS-1));
        fin    = adv && (b == ButtWL'(BUTTERFLYES-1)) && (l == LayWL'(LAYERS-1));
        nb     = wrap ? '0 : b + ButtWL'(1);
        nl     = wrap ? l + LayWL'(1) : l;
        // A inserts a zero bit at position nl into nb; B sets that bit.
        span   = LAYERS'(1) << nl;
        pos    = nb & ButtWL'(span - LAYERS'(1));
        grp    = LAYERS'(nb) >> nl;
        a_n    = (grp << (nl + LayWL'(1))) | LAYERS'(pos);
        b_n    = a_n + span;
        tw_n   = pos << (LAYERS - 1 - int'(nl));
        // LAY_EN is only legal right after (or together with) a wrapping ADDR_EN.
        lay_ok = adv ? wrap : last_wrap;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            b         <= '0;
            l         <= '0;
            wcnt      <= '0;
            iss_done  <= 1'b0;
            last_wrap <= 1'b0;
            RD_ADDR_A <= '0;
            RD_ADDR_B <= '0;
            WR_ADDR_A <= '0;
            WR_ADDR_B <= '0;
            TW_ADDR   <= '0;
            WE        <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            SYNC_ERR  <= 1'b0;
        end else if (EN) begin
            WE   <= 1'b0;
            DONE <= 1'b0;
            if (START) begin
                b         <= '0;
                l         <= '0;
                wcnt      <= '0;
                iss_done  <= 1'b0;
                last_wrap <= 1'b1;
                BUSY      <= 1'b1;
                SYNC_ERR  <= 1'b0;
                RD_ADDR_A <= '0;
                RD_ADDR_B <= LAYERS'(1);
                TW_ADDR   <= '0;
            end else if (BUSY) begin
                if (fin) begin
                    iss_done  <= 1'b1;
                    last_wrap <= 1'b0;
                end else if (adv) begin
                    b         <= nb;
                    l         <= nl;
                    last_wrap <= wrap;
                    RD_ADDR_A <= a_n;
                    RD_ADDR_B <= b_n;
                    TW_ADDR   <= tw_n;
                end
                if (BUT_STROB) begin
                    WR_ADDR_A <= RD_ADDR_A;
                    WR_ADDR_B <= RD_ADDR_B;
                    if (FIRST != (l == '0))
                        SYNC_ERR <= 1'b1;
                end
                if (LAY_EN && !lay_ok)
                    SYNC_ERR <= 1'b1;
                if (Wr) begin
                    WE   <= 1'b1;
                    wcnt <= wcnt + WCW'(1);
                    if (wcnt == WCW'(LAYERS*BUTTERFLYES-1)) begin
                        DONE <= 1'b1;
                        BUSY <= 1'b0;
                    end
                end
            end
        end
    end
endmodule
